// File: rtl/unified_mem_scheduler.sv
// rtl/unified_mem_scheduler.sv - shares one single-port RAM between core fetch and data accesses
module unified_mem_scheduler #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              cpu_active,
    output logic              cpu_clk_enable,
    input  logic [31:0]       instr_address,
    output logic [31:0]       instr_readdata,
    input  logic [31:0]       data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [31:0]       data_writedata,
    output logic [31:0]       data_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              halted,
    output logic              error
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_EXEC,
        S_LWAIT,
        S_COMMIT,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;
    logic [31:0] data_q;
    logic        halted_q;
    logic        error_q;
    logic        set_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            instr_q  <= 32'h0;
            data_q   <= 32'h0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_FWAIT) begin
                instr_q <= mem_readdata;
            end
            if (state == S_LWAIT) begin
                data_q <= mem_readdata;
            end
            if (set_error) begin
                error_q <= 1'b1;
            end
            if (state_next == S_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        cpu_clk_enable = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = 32'h0;
        set_error      = 1'b0;
        case (state)
            S_FETCH: begin
                if (clk_enable) begin
                    mem_read    = 1'b1;
                    mem_address = ADDR_W'(instr_address);
                    state_next  = S_FWAIT;
                end
            end
            S_FWAIT: state_next = S_EXEC;
            S_EXEC: begin
                if (data_read && data_write) begin
                    set_error  = 1'b1;
                    state_next = S_HALT;
                end else if (data_read) begin
                    mem_read    = 1'b1;
                    mem_address = ADDR_W'(data_address);
                    state_next  = S_LWAIT;
                end else begin
                    // Store (if any) lands in the same cycle the core commits.
                    cpu_clk_enable = 1'b1;
                    if (data_write) begin
                        mem_write     = 1'b1;
                        mem_address   = ADDR_W'(data_address);
                        mem_writedata = data_writedata;
                    end
                    state_next = cpu_active ? S_FETCH : S_HALT;
                end
            end
            S_LWAIT: state_next = S_COMMIT;
            S_COMMIT: begin
                cpu_clk_enable = 1'b1;
                state_next     = cpu_active ? S_FETCH : S_HALT;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // Reset must suppress any write or commit the current state would issue.
        if (reset) begin
            cpu_clk_enable = 1'b0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_address    = '0;
            mem_writedata  = 32'h0;
            set_error      = 1'b0;
        end
    end

    assign instr_readdata = instr_q;
    assign data_readdata  = data_q;
    assign halted         = halted_q;
    assign error          = error_q;

endmodule

// File: tb/tb_unified_mem_scheduler.sv
// tb/tb_unified_mem_scheduler.sv - scoreboard bench for unified_mem_scheduler
module tb_unified_mem_scheduler;

    localparam logic [31:0] RST_VEC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        halted;
    logic        error;

    always #5 clk = ~clk;

    unified_mem_scheduler #(.ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .cpu_active     (cpu_active),
        .cpu_clk_enable (cpu_clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .halted         (halted),
        .error          (error)
    );

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic        cce;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] instr;
        logic [31:0] data;
        logic        hl;
        logic        er;
    } exp_t;

    logic [31:0] ram     [logic [31:0]];
    logic [31:0] exp_mem [logic [31:0]];
    exp_t        sb [$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;

    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_data  = 32'h0;
    logic        m_halt  = 1'b0;
    logic        m_err   = 1'b0;

    // Single-port synchronous RAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_write) ram[mem_address] = mem_writedata;
        if (mem_read) mem_readdata <= ram.exists(mem_address) ? ram[mem_address] : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] emem(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("mem_read",       {31'h0, mem_read},       {31'h0, mon_e.mr});
            chk("mem_write",      {31'h0, mem_write},      {31'h0, mon_e.mw});
            chk("cpu_clk_enable", {31'h0, cpu_clk_enable}, {31'h0, mon_e.cce});
            chk("mem_address",    mem_address,             mon_e.addr);
            chk("mem_writedata",  mem_writedata,           mon_e.wd);
            chk("instr_readdata", instr_readdata,          mon_e.instr);
            chk("data_readdata",  data_readdata,           mon_e.data);
            chk("halted",         {31'h0, halted},         {31'h0, mon_e.hl});
            chk("error",          {31'h0, error},          {31'h0, mon_e.er});
        end
        if (mem_read && mem_write) chk("rw_exclusive", 32'h1, 32'h0);
    end

    task automatic step(input logic mr, input logic mw, input logic cce,
                        input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        e.mr = mr; e.mw = mw; e.cce = cce; e.addr = addr; e.wd = wd;
        e.instr = m_instr; e.data = m_data; e.hl = m_halt; e.er = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        quiet();
        m_instr = 32'h0; m_data = 32'h0; m_halt = 1'b0; m_err = 1'b0;
        reset = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] ia, input logic dr, input logic dw,
                            input logic [31:0] da, input logic [31:0] wd,
                            input logic act, input logic ce_after, input logic rst_lwait);
        clk_enable = 1'b1; instr_address = ia; cpu_active = 1'b1;
        data_read = dr; data_write = dw; data_address = da; data_writedata = wd;
        step(1'b1, 1'b0, 1'b0, ia, 32'h0);
        clk_enable = ce_after;
        quiet();
        m_instr = emem(ia);
        cpu_active = act;
        if (dr && dw) begin
            quiet();
            m_halt = 1'b1; m_err = 1'b1;
        end else if (dr) begin
            step(1'b1, 1'b0, 1'b0, da, 32'h0);
            if (rst_lwait) begin
                do_reset();
            end else begin
                quiet();
                m_data = emem(da);
                step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
                if (!act) m_halt = 1'b1;
            end
        end else begin
            step(1'b0, dw, 1'b1, dw ? da : 32'h0, dw ? wd : 32'h0);
            if (dw) exp_mem[da] = wd;
            if (!act) m_halt = 1'b1;
        end
        data_read = 1'b0; data_write = 1'b0; cpu_active = 1'b1;
    endtask

    initial begin
        logic [31:0] init_a [6];
        logic [31:0] init_d [6];
        init_a = '{RST_VEC, RST_VEC + 4, RST_VEC + 8, 32'h100, 32'h200, 32'h104};
        init_d = '{32'h0, 32'h8C080100, 32'hAC090104, 32'hDEADBEEF, 32'hAAAAAAAA, 32'h0};
        for (int i = 0; i < 6; i++) begin
            ram[init_a[i]]     = init_d[i];
            exp_mem[init_a[i]] = init_d[i];
        end

        reset = 1'b1; clk_enable = 1'b0; cpu_active = 1'b1;
        instr_address = RST_VEC; data_address = 32'h0;
        data_read = 1'b0; data_write = 1'b0; data_writedata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        repeat (3) do_instr(RST_VEC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        do_instr(RST_VEC + 4, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0);
        do_instr(RST_VEC + 8, 1'b0, 1'b1, 32'h104, 32'h12345678, 1'b1, 1'b1, 1'b0);
        do_instr(RST_VEC, 1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b1, 1'b0);

        clk_enable = 1'b0;
        repeat (4) quiet();
        do_instr(RST_VEC + 4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        do_instr(RST_VEC + 8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        quiet();

        do_instr(RST_VEC + 4, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 1'b1);
        do_instr(RST_VEC + 8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Reset landing on a store's EXEC cycle must not write
        clk_enable = 1'b1; instr_address = RST_VEC + 8;
        data_write = 1'b1; data_address = 32'h300; data_writedata = 32'h55;
        step(1'b1, 1'b0, 1'b0, RST_VEC + 8, 32'h0);
        quiet();
        m_instr = emem(RST_VEC + 8);
        do_reset();
        data_write = 1'b0;
        do_instr(RST_VEC, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b1, 1'b0);

        do_instr(RST_VEC + 4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        clk_enable = 1'b1; data_write = 1'b1; data_address = 32'h104;
        repeat (3) quiet();
        data_write = 1'b0;
        do_reset();

        do_instr(RST_VEC + 4, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        clk_enable = 1'b1;
        repeat (2) quiet();
        do_reset();

        do_instr(RST_VEC + 8, 1'b1, 1'b1, 32'h104, 32'h99, 1'b1, 1'b1, 1'b0);
        clk_enable = 1'b1; data_write = 1'b1; data_read = 1'b0; data_address = 32'h104;
        repeat (4) quiet();
        data_write = 1'b0;
        do_reset();
        do_instr(RST_VEC + 4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
